// File: rtl/line_sequencer.sv
// First-octant Bresenham line micro-sequencer: drives one DPU micro-op per clock
// and raises plot_req for each pixel while the DPU Kbus carries X, Y and colour.
module line_sequencer #(
   parameter logic [3:0] OP_SUB  = 4'd1,
   parameter logic [3:0] OP_SHL  = 4'd2,
   parameter logic [3:0] OP_INC  = 4'd3,
   parameter logic [3:0] OP_ADD  = 4'd4,
   parameter logic [3:0] OP_LOAD = 4'd8,
   parameter logic [3:0] OP_NOP  = 4'd15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] xs,
   input  logic [7:0] ys,
   input  logic [7:0] xe,
   input  logic [7:0] ye,
   input  logic [7:0] colour,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       plot_req,
   input  logic       plot_ack,
   output logic [3:0] dpu_a,
   output logic [3:0] dpu_b,
   output logic [3:0] dpu_r,
   output logic [3:0] dpu_n,
   output logic [7:0] dpu_mdata,
   input  logic [3:0] dpu_cc
);

   localparam logic [3:0] R_DX     = 4'd0;
   localparam logic [3:0] R_DY     = 4'd1;
   localparam logic [3:0] R_E      = 4'd2;
   localparam logic [3:0] R_EINC   = 4'd3;
   localparam logic [3:0] R_ENOINC = 4'd4;
   localparam logic [3:0] R_XS     = 4'd5;
   localparam logic [3:0] R_XE     = 4'd6;
   localparam logic [3:0] R_YS     = 4'd7;
   localparam logic [3:0] R_YE     = 4'd8;
   localparam logic [3:0] R_X      = 4'd9;
   localparam logic [3:0] R_Y      = 4'd10;
   localparam logic [3:0] R_COL    = 4'd11;
   localparam logic [3:0] R_TMP    = 4'd12;

   typedef enum logic [4:0] {
      S_IDLE, S_LD_XS, S_LD_YS, S_LD_XE, S_LD_YE, S_LD_COL, S_LD_X, S_LD_Y,
      S_DX, S_DXC, S_DY, S_DYC, S_DYDX, S_DYDXC,
      S_SHL, S_EINC1, S_EINC2, S_E0, S_E0C,
      S_PLOT, S_CMP, S_CMPC, S_XSTEP, S_YSTEP, S_EUPD, S_ECHK,
      S_DONE, S_ERR
   } state_t;

   state_t     state, state_nx;
   logic [7:0] xs_q, ys_q, xe_q, ye_q, col_q;
   logic       e_neg;
   logic       range_bad;
   logic       cc_z, cc_n;
   logic [1:0] unused_cc;

   assign cc_z      = dpu_cc[0];
   assign cc_n      = dpu_cc[1];
   assign unused_cc = dpu_cc[3:2];
   assign range_bad = |{xs[7:6], ys[7:6], xe[7:6], ye[7:6]};

   // State register, command latch and the sign of the running error term
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         xs_q  <= 8'd0;
         ys_q  <= 8'd0;
         xe_q  <= 8'd0;
         ye_q  <= 8'd0;
         col_q <= 8'd0;
         e_neg <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && start) begin
            xs_q  <= xs;
            ys_q  <= ys;
            xe_q  <= xe;
            ye_q  <= ye;
            col_q <= colour;
         end
         if (state == S_E0C || state == S_ECHK)
            e_neg <= cc_n;
      end
   end

   // Micro-op issue and next-state; the *C states consume the flags of the op before
   always_comb begin
      state_nx  = state;
      busy      = 1'b1;
      done      = 1'b0;
      err       = 1'b0;
      plot_req  = 1'b0;
      dpu_n     = OP_NOP;
      dpu_a     = 4'd0;
      dpu_b     = 4'd0;
      dpu_r     = 4'd0;
      dpu_mdata = 8'd0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start)
               state_nx = range_bad ? S_ERR : S_LD_XS;
         end
         S_LD_XS:  begin dpu_n = OP_LOAD; dpu_r = R_XS;  dpu_mdata = xs_q;  state_nx = S_LD_YS;  end
         S_LD_YS:  begin dpu_n = OP_LOAD; dpu_r = R_YS;  dpu_mdata = ys_q;  state_nx = S_LD_XE;  end
         S_LD_XE:  begin dpu_n = OP_LOAD; dpu_r = R_XE;  dpu_mdata = xe_q;  state_nx = S_LD_YE;  end
         S_LD_YE:  begin dpu_n = OP_LOAD; dpu_r = R_YE;  dpu_mdata = ye_q;  state_nx = S_LD_COL; end
         S_LD_COL: begin dpu_n = OP_LOAD; dpu_r = R_COL; dpu_mdata = col_q; state_nx = S_LD_X;   end
         S_LD_X:   begin dpu_n = OP_LOAD; dpu_r = R_X;   dpu_mdata = xs_q;  state_nx = S_LD_Y;   end
         S_LD_Y:   begin dpu_n = OP_LOAD; dpu_r = R_Y;   dpu_mdata = ys_q;  state_nx = S_DX;     end
         S_DX:     begin dpu_n = OP_SUB; dpu_r = R_DX; dpu_a = R_XE; dpu_b = R_XS; state_nx = S_DXC; end
         S_DXC:    state_nx = cc_n ? S_ERR : S_DY;
         S_DY:     begin dpu_n = OP_SUB; dpu_r = R_DY; dpu_a = R_YE; dpu_b = R_YS; state_nx = S_DYC; end
         S_DYC:    state_nx = cc_n ? S_ERR : S_DYDX;
         S_DYDX:   begin dpu_n = OP_SUB; dpu_r = R_TMP; dpu_a = R_DX; dpu_b = R_DY; state_nx = S_DYDXC; end
         S_DYDXC:  state_nx = cc_n ? S_ERR : S_SHL;
         S_SHL:    begin dpu_n = OP_SHL; dpu_r = R_ENOINC; dpu_a = R_DY; state_nx = S_EINC1; end
         S_EINC1:  begin dpu_n = OP_SUB; dpu_r = R_EINC; dpu_a = R_ENOINC; dpu_b = R_DX; state_nx = S_EINC2; end
         S_EINC2:  begin dpu_n = OP_SUB; dpu_r = R_EINC; dpu_a = R_EINC; dpu_b = R_DX; state_nx = S_E0; end
         S_E0:     begin dpu_n = OP_SUB; dpu_r = R_E; dpu_a = R_ENOINC; dpu_b = R_DX; state_nx = S_E0C; end
         S_E0C:    state_nx = S_PLOT;
         S_PLOT: begin
            plot_req = 1'b1;
            if (plot_ack)
               state_nx = S_CMP;
         end
         S_CMP:    begin dpu_n = OP_SUB; dpu_r = R_TMP; dpu_a = R_X; dpu_b = R_XE; state_nx = S_CMPC; end
         S_CMPC:   state_nx = cc_z ? S_DONE : S_XSTEP;
         S_XSTEP:  begin dpu_n = OP_INC; dpu_r = R_X; dpu_a = R_X; state_nx = S_YSTEP; end
         S_YSTEP: begin
            if (!e_neg) begin
               dpu_n = OP_INC;
               dpu_r = R_Y;
               dpu_a = R_Y;
            end
            state_nx = S_EUPD;
         end
         S_EUPD: begin
            dpu_n    = OP_ADD;
            dpu_r    = R_E;
            dpu_a    = R_E;
            dpu_b    = e_neg ? R_ENOINC : R_EINC;
            state_nx = S_ECHK;
         end
         S_ECHK:   state_nx = S_PLOT;
         S_DONE:   begin done = 1'b1; state_nx = S_IDLE; end
         S_ERR:    begin err  = 1'b1; state_nx = S_IDLE; end
         default:  state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_line_sequencer.sv
// Bench for line_sequencer: a small DPU register-file model closes the loop, and
// each line is compared against a plain Bresenham walk with the expected cycle timing.
module tb_line_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] xs, ys, xe, ye, colour;
   logic       busy, done, err, plot_req, plot_ack;
   logic [3:0] dpu_a, dpu_b, dpu_r, dpu_n;
   logic [7:0] dpu_mdata;
   logic [3:0] dpu_cc = 4'd0;

   logic [7:0] regs [16];

   int errors = 0;
   int checks = 0;

   line_sequencer dut (
      .clk(clk), .reset(reset), .start(start),
      .xs(xs), .ys(ys), .xe(xe), .ye(ye), .colour(colour),
      .busy(busy), .done(done), .err(err),
      .plot_req(plot_req), .plot_ack(plot_ack),
      .dpu_a(dpu_a), .dpu_b(dpu_b), .dpu_r(dpu_r), .dpu_n(dpu_n),
      .dpu_mdata(dpu_mdata), .dpu_cc(dpu_cc)
   );

   always #5 clk = ~clk;

   // DPU model: executes the issued op at the clock edge, flags registered with the result
   always @(posedge clk) begin
      logic [7:0] a, b, res;
      logic       wr;
      a   = regs[dpu_a];
      b   = regs[dpu_b];
      res = 8'd0;
      wr  = 1'b1;
      case (dpu_n)
         4'd1:    res = a - b;
         4'd2:    res = a << 1;
         4'd3:    res = a + 8'd1;
         4'd4:    res = a + b;
         4'd8:    res = dpu_mdata;
         default: wr = 1'b0;
      endcase
      if (wr) begin
         regs[dpu_r] <= res;
         dpu_cc      <= {2'b00, res[7], (res == 8'd0)};
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Issues one command and watches it cycle by cycle; k counts cycles after the start edge
   task automatic applyStimulus(input int lxs, input int lys, input int lxe, input int lye,
                                input int lcol, input int ackDly, input int pokeCycle,
                                input string tag);
      int expErr, expDone, endCyc;
      int expPx[$];
      int expCyc[$];
      int obsPx[$];
      int obsCyc[$];
      int runLens[$];
      int doneCnt, errCnt, doneCyc, errCyc, opCnt, busyErrs, colErrs, run, stopAt;
      int dx, dy, x, y, e, c;
      logic prevReq;
      bit   finished;
      logic [31:0] colv;

      doneCnt = 0; errCnt = 0; doneCyc = -1; errCyc = -1; opCnt = 0;
      busyErrs = 0; colErrs = 0; run = 0; stopAt = -1; prevReq = 1'b0; finished = 1'b0;
      colv = lcol;
      dx = lxe - lxs;
      dy = lye - lys;
      expErr  = 0;
      expDone = 0;
      if (lxs > 63 || lys > 63 || lxe > 63 || lye > 63) expErr = 1;
      else if (dx < 0)  expErr = 10;
      else if (dy < 0)  expErr = 12;
      else if (dy > dx) expErr = 14;
      else begin
         x = lxs; y = lys; e = 2 * dy - dx; c = 19;
         for (int g = 0; g < 70; g++) begin
            expPx.push_back(x * 256 + y);
            expCyc.push_back(c);
            if (x == lxe) break;
            if (e >= 0) begin
               y++;
               e += 2 * dy - 2 * dx;
            end else
               e += 2 * dy;
            x++;
            c += 7 + ackDly;
         end
         expDone = c + ackDly + 3;
      end
      endCyc = (expErr != 0) ? expErr : expDone;

      @(negedge clk);
      xs = lxs[7:0]; ys = lys[7:0]; xe = lxe[7:0]; ye = lye[7:0]; colour = colv[7:0];
      start    = 1'b1;
      plot_ack = (ackDly == 0);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 4000; k++) begin
         if (busy !== (k <= endCyc)) busyErrs++;
         if (done === 1'b1) begin doneCnt++; doneCyc = k; end
         if (err === 1'b1)  begin errCnt++;  errCyc = k;  end
         if (dpu_n !== 4'd15) opCnt++;
         if (plot_req === 1'b1) begin
            if (!prevReq) begin
               obsPx.push_back(int'(regs[9]) * 256 + int'(regs[10]));
               obsCyc.push_back(k);
               run = 0;
               if (regs[11] !== colv[7:0]) colErrs++;
            end
            run++;
         end else if (prevReq)
            runLens.push_back(run);
         prevReq = plot_req;
         if (ackDly > 0) plot_ack = plot_req && (run >= ackDly + 1);
         if (k == pokeCycle) begin
            start = 1'b1;
            xs = 8'd40; ys = 8'd1; xe = 8'd7; ye = 8'd60; colour = 8'hFF;
         end else
            start = 1'b0;
         if ((done === 1'b1 || err === 1'b1) && stopAt < 0) stopAt = k + 1;
         if (k == stopAt) begin
            finished = 1'b1;
            break;
         end
         @(negedge clk);
      end
      start    = 1'b0;
      plot_ack = 1'b0;

      checkOutput({tag, " finished"}, 32'(finished), 32'd1);
      checkOutput({tag, " busy window"}, busyErrs, 0);
      if (expErr != 0) begin
         checkOutput({tag, " err cycle"}, errCyc, expErr);
         checkOutput({tag, " err count"}, errCnt, 1);
         checkOutput({tag, " done count"}, doneCnt, 0);
         checkOutput({tag, " plot count"}, obsPx.size(), 0);
         if (expErr == 1)
            checkOutput({tag, " ops issued"}, opCnt, 0);
      end else begin
         checkOutput({tag, " done cycle"}, doneCyc, expDone);
         checkOutput({tag, " done count"}, doneCnt, 1);
         checkOutput({tag, " err count"}, errCnt, 0);
         checkOutput({tag, " plot count"}, obsPx.size(), expPx.size());
         for (int i = 0; i < expPx.size() && i < obsPx.size(); i++) begin
            checkOutput($sformatf("%s pixel%0d", tag, i), obsPx[i], expPx[i]);
            checkOutput($sformatf("%s plot cycle%0d", tag, i), obsCyc[i], expCyc[i]);
         end
         checkOutput({tag, " req runs"}, runLens.size(), expPx.size());
         for (int i = 0; i < runLens.size(); i++)
            checkOutput($sformatf("%s req len%0d", tag, i), runLens[i], ackDly + 1);
         checkOutput({tag, " final X"}, regs[9], lxe);
         checkOutput({tag, " final Y"}, regs[10], lye);
         checkOutput({tag, " colour on Kbus"}, colErrs, 0);
      end
   endtask

   initial begin
      int rises, quiet, xs0, xe0, ys0, ye0, dymax, dly;
      logic prev;
      foreach (regs[i]) regs[i] = 8'd0;
      reset = 1'b1; start = 1'b0; plot_ack = 1'b0;
      xs = 8'd0; ys = 8'd0; xe = 8'd0; ye = 8'd0; colour = 8'd0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset err", err, 0);
      checkOutput("reset plot_req", plot_req, 0);
      checkOutput("reset dpu_n", dpu_n, 15);
      checkOutput("reset dpu_a/b/r", {dpu_a, dpu_b, dpu_r}, 0);
      checkOutput("reset dpu_mdata", dpu_mdata, 0);
      reset = 1'b0;

      $display("[TB] directed lines");
      applyStimulus(0, 0, 3, 1, 8'h2A, 0, -1, "diag");
      applyStimulus(5, 5, 5, 5, 8'h33, 0, -1, "single");
      applyStimulus(0, 3, 2, 3, 8'h44, 3, -1, "horiz slow ack");
      applyStimulus(10, 0, 2, 0, 8'h01, 0, -1, "dx negative");
      applyStimulus(0, 5, 4, 2, 8'h02, 0, -1, "dy negative");
      applyStimulus(0, 0, 2, 5, 8'h03, 0, -1, "dy gt dx");
      applyStimulus(0, 0, 64, 0, 8'h04, 0, -1, "xe range");
      applyStimulus(2, 3, 9, 6, 8'h5A, 1, 5, "start while busy");
      applyStimulus(0, 0, 63, 63, 8'h77, 0, 21, "full diagonal");

      $display("[TB] reset during second plot");
      @(negedge clk);
      xs = 8'd0; ys = 8'd0; xe = 8'd3; ye = 8'd1; colour = 8'h11;
      start = 1'b1; plot_ack = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rises = 0; prev = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (plot_req === 1'b1 && !prev) rises++;
         prev = plot_req;
         if (rises == 2) break;
         @(negedge clk);
      end
      checkOutput("rst reached 2nd plot", rises, 2);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst plot_req", plot_req, 0);
      checkOutput("rst dpu_n", dpu_n, 15);
      checkOutput("rst dpu_a/b/r/mdata", {dpu_a, dpu_b, dpu_r, dpu_mdata}, 0);
      reset = 1'b0;
      quiet = 0;
      for (int k = 0; k < 8; k++) begin
         if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) quiet++;
         @(negedge clk);
      end
      checkOutput("rst no pulse after abandon", quiet, 0);
      plot_ack = 1'b0;
      applyStimulus(1, 1, 2, 2, 8'h66, 0, -1, "after reset");

      $display("[TB] random first-octant lines");
      for (int i = 0; i < 10; i++) begin
         xs0   = $urandom_range(63, 0);
         xe0   = $urandom_range(63, xs0);
         ys0   = $urandom_range(63, 0);
         dymax = (xe0 - xs0 < 63 - ys0) ? (xe0 - xs0) : (63 - ys0);
         ye0   = ys0 + $urandom_range(dymax, 0);
         dly   = $urandom_range(3, 0);
         applyStimulus(xs0, ys0, xe0, ye0, $urandom_range(255, 0), dly, -1,
                       $sformatf("rand%0d", i));
      end
      $display("[TB] random unconstrained commands");
      for (int i = 0; i < 8; i++) begin
         applyStimulus($urandom_range(67, 0), $urandom_range(67, 0), $urandom_range(67, 0),
                       $urandom_range(67, 0), $urandom_range(255, 0), $urandom_range(2, 0),
                       -1, $sformatf("any%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
